// File: rtl/cpu_design.sv
// Single-cycle RV32I subset core: combinational code and data memory reads,
// with all state updated on the rising clk edge and an asynchronous active-high reset.

module code_memory #(
  parameter int unsigned CODE_WORDS = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_we,
  input  logic [$clog2(CODE_WORDS)-1:0] i_waddr,
  input  logic [31:0]                   i_wdata,
  input  logic [31:0]                   i_pc,
  output logic [31:0]                   o_instr
);
  localparam int unsigned CW = $clog2(CODE_WORDS);

  logic [31:0] memory [0:CODE_WORDS-1];
  logic        w_unused;

  // PC is a byte address; the word index wraps modulo the memory depth.
  assign o_instr  = memory[i_pc[CW+1:2]];
  assign w_unused = ^{i_pc[31:CW+2], i_pc[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_we) memory[i_waddr] <= i_wdata;
  end
endmodule

module data_memory #(
  parameter int unsigned DATA_BYTES = 4096
) (
  input  logic        i_clk,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  localparam int unsigned AW = $clog2(DATA_BYTES);

  logic [7:0] r_mem [0:DATA_BYTES-1];
  logic       w_unused;

  assign o_rdata = {r_mem[{i_addr[AW-1:2], 2'd3}], r_mem[{i_addr[AW-1:2], 2'd2}],
                    r_mem[{i_addr[AW-1:2], 2'd1}], r_mem[{i_addr[AW-1:2], 2'd0}]};
  assign w_unused = ^{i_addr[31:AW], i_addr[1:0]};

  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (i_be[k]) r_mem[{i_addr[AW-1:2], 2'(k)}] <= i_wdata[8*k +: 8];
    end
  end
endmodule

module cpu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_drdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_daddr,
  output logic [3:0]  o_dbe,
  output logic [31:0] o_dwdata,
  output logic        o_halted
);
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  logic [31:0] register_bank [0:31];
  logic [31:0] r_pc;
  logic        r_halted;

  opcode_e     w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_rs1v, w_rs2v, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_ea_ld, w_ea_st, w_lword, w_opb, w_pc4;
  logic [15:0] w_lhalf;
  logic        w_ebreak, w_alt, w_taken, w_rd_we;
  logic [31:0] w_rd_val, w_next_pc, w_wdata;
  logic [3:0]  w_be;

  assign w_opcode = opcode_e'(i_instr[6:0]);
  assign w_rd     = i_instr[11:7];
  assign w_f3     = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_f7     = i_instr[31:25];
  assign w_rs1v   = register_bank[w_rs1];
  assign w_rs2v   = register_bank[w_rs2];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'h000};
  assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_pc4    = r_pc + 32'd4;
  assign w_ebreak = (i_instr == 32'h0010_0073);
  assign w_alt    = (w_f7 == 7'b0100000);

  // Register-register and immediate ALU ops share one datapath; only operand B differs.
  assign w_opb    = (w_opcode == OP_REG) ? w_rs2v : w_imm_i;
  assign w_shamt  = w_opb[4:0];

  assign w_ea_ld  = w_rs1v + w_imm_i;
  assign w_ea_st  = w_rs1v + w_imm_s;
  assign w_lword  = i_drdata >> {w_ea_ld[1:0], 3'b000};
  assign w_lhalf  = w_ea_ld[1] ? i_drdata[31:16] : i_drdata[15:0];

  always_comb begin
    w_next_pc = w_pc4;
    w_rd_we   = 1'b0;
    w_rd_val  = '0;
    w_be      = '0;
    w_wdata   = '0;
    w_taken   = 1'b0;
    case (w_opcode)
      OP_LUI:   begin w_rd_we = 1'b1; w_rd_val = w_imm_u; end
      OP_AUIPC: begin w_rd_we = 1'b1; w_rd_val = r_pc + w_imm_u; end
      OP_JAL: begin
        w_rd_we   = 1'b1;
        w_rd_val  = w_pc4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        if (w_f3 == 3'b000) begin
          w_rd_we   = 1'b1;
          w_rd_val  = w_pc4;
          w_next_pc = (w_rs1v + w_imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        case (w_f3)
          3'b000:  w_taken = (w_rs1v == w_rs2v);
          3'b001:  w_taken = (w_rs1v != w_rs2v);
          3'b100:  w_taken = ($signed(w_rs1v) < $signed(w_rs2v));
          3'b101:  w_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
          3'b110:  w_taken = (w_rs1v < w_rs2v);
          3'b111:  w_taken = (w_rs1v >= w_rs2v);
          default: w_taken = 1'b0;
        endcase
        if (w_taken) w_next_pc = r_pc + w_imm_b;
      end
      OP_LOAD: begin
        w_rd_we = 1'b1;
        case (w_f3)
          3'b000:  w_rd_val = {{24{w_lword[7]}}, w_lword[7:0]};
          3'b001:  w_rd_val = {{16{w_lhalf[15]}}, w_lhalf};
          3'b010:  w_rd_val = i_drdata;
          3'b100:  w_rd_val = {24'h0, w_lword[7:0]};
          3'b101:  w_rd_val = {16'h0, w_lhalf};
          default: w_rd_we  = 1'b0;
        endcase
      end
      OP_STORE: begin
        case (w_f3)
          3'b000:  begin w_be = 4'b0001 << w_ea_st[1:0]; w_wdata = {4{w_rs2v[7:0]}}; end
          3'b001:  begin w_be = w_ea_st[1] ? 4'b1100 : 4'b0011; w_wdata = {2{w_rs2v[15:0]}}; end
          3'b010:  begin w_be = 4'b1111; w_wdata = w_rs2v; end
          default: w_be = '0;
        endcase
      end
      OP_IMM, OP_REG: begin
        w_rd_we = 1'b1;
        case (w_f3)
          3'b000: begin
            if (w_opcode == OP_REG && w_alt)         w_rd_val = w_rs1v - w_opb;
            else if (w_opcode == OP_IMM || w_f7 == '0) w_rd_val = w_rs1v + w_opb;
            else                                     w_rd_we  = 1'b0;
          end
          3'b001: begin
            if (w_f7 == '0) w_rd_val = w_rs1v << w_shamt;
            else            w_rd_we  = 1'b0;
          end
          3'b101: begin
            if (w_alt)           w_rd_val = 32'($signed(w_rs1v) >>> w_shamt);
            else if (w_f7 == '0) w_rd_val = w_rs1v >> w_shamt;
            else                 w_rd_we  = 1'b0;
          end
          default: begin
            if (w_opcode == OP_REG && w_f7 != '0) w_rd_we = 1'b0;
            case (w_f3)
              3'b010:  w_rd_val = {31'h0, $signed(w_rs1v) < $signed(w_opb)};
              3'b011:  w_rd_val = {31'h0, w_rs1v < w_opb};
              3'b100:  w_rd_val = w_rs1v ^ w_opb;
              3'b110:  w_rd_val = w_rs1v | w_opb;
              default: w_rd_val = w_rs1v & w_opb;
            endcase
          end
        endcase
      end
      default: w_rd_we = 1'b0;
    endcase
  end

  assign o_pc     = r_pc;
  assign o_halted = r_halted;
  assign o_daddr  = (w_opcode == OP_STORE) ? w_ea_st : w_ea_ld;
  assign o_dwdata = w_wdata;
  // Stores are blocked while halted or in reset so an aborted program cannot corrupt data.
  assign o_dbe    = (r_halted || i_rst) ? 4'b0000 : w_be;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc     <= '0;
      r_halted <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) register_bank[i] <= '0;
    end else if (!r_halted) begin
      if (w_ebreak) begin
        r_halted <= 1'b1;
      end else begin
        r_pc <= w_next_pc;
        if (w_rd_we && w_rd != 5'd0) register_bank[w_rd] <= w_rd_val;
      end
    end
  end
endmodule

module cpu_design #(
  parameter int unsigned CODE_WORDS = 1024,
  parameter int unsigned DATA_BYTES = 4096
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);
  logic [31:0]                   w_pc, w_instr, w_daddr, w_dwdata, w_drdata;
  logic [3:0]                    w_dbe;
  logic                          w_cm_we;
  logic [$clog2(CODE_WORDS)-1:0] w_cm_waddr;
  logic [31:0]                   w_cm_wdata;

  // Code memory is loaded hierarchically; its write port stays idle.
  assign w_cm_we    = 1'b0;
  assign w_cm_waddr = '0;
  assign w_cm_wdata = '0;

  code_memory #(.CODE_WORDS(CODE_WORDS)) u_code_memory (
    .i_clk   (clk),
    .i_we    (w_cm_we),
    .i_waddr (w_cm_waddr),
    .i_wdata (w_cm_wdata),
    .i_pc    (w_pc),
    .o_instr (w_instr)
  );

  data_memory #(.DATA_BYTES(DATA_BYTES)) u_data_memory (
    .i_clk   (clk),
    .i_addr  (w_daddr),
    .i_be    (w_dbe),
    .i_wdata (w_dwdata),
    .o_rdata (w_drdata)
  );

  cpu u_cpu (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_instr  (w_instr),
    .i_drdata (w_drdata),
    .o_pc     (w_pc),
    .o_daddr  (w_daddr),
    .o_dbe    (w_dbe),
    .o_dwdata (w_dwdata),
    .o_halted (halted)
  );
endmodule

// File: tb/tb_cpu_design.sv
// Directed programme bench for cpu_design: Fibonacci, store/load loop,
// sign/zero extension and mixed ALU/branch/jump, halt freeze and reset abort.

module tb_cpu_design;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc;
  logic [31:0] prog[$];

  cpu_design #(.CODE_WORDS(1024), .DATA_BYTES(4096)) dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction

  task automatic emit(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic build_fib();
    prog.delete();
    emit(addi(1, 0, 1));
    emit(enc_s(0, 1, 0, 3'd2));
    emit(enc_s(4, 1, 0, 3'd2));
    emit(addi(2, 0, 0));
    emit(addi(3, 0, 48));
    emit(enc_i(0, 2, 3'd2, 4, 7'h03));       // 20: lw x4,0(x2)
    emit(enc_i(4, 2, 3'd2, 5, 7'h03));
    emit(enc_r(7'h00, 5, 4, 3'd0, 6));
    emit(enc_s(8, 6, 2, 3'd2));
    emit(addi(2, 2, 4));
    emit(enc_b(-20, 3, 2, 3'd4));            // 40: blt x2,x3,-20
    emit(enc_u(20'h600D6, 10, 7'h37));
    emit(addi(10, 10, 13));
    emit(32'h0010_0073);                     // 52: ebreak
  endtask

  task automatic build_ldst();
    prog.delete();
    emit(addi(1, 0, 0));
    emit(addi(2, 0, 16));
    emit(addi(11, 0, 0));
    emit(enc_s(0, 1, 1, 3'd0));              // 12: sb x1,0(x1)
    emit(enc_i(1, 1, 3'd1, 3, 7'h13));
    emit(enc_s(32, 1, 3, 3'd1));
    emit(enc_i(2, 1, 3'd1, 4, 7'h13));
    emit(enc_s(128, 1, 4, 3'd2));
    emit(addi(1, 1, 1));
    emit(enc_b(-24, 2, 1, 3'd4));            // 36
    emit(addi(1, 0, 0));
    emit(enc_i(0, 1, 3'd4, 5, 7'h03));       // 44: lbu x5,0(x1)
    emit(enc_i(1, 1, 3'd1, 3, 7'h13));
    emit(enc_i(32, 3, 3'd5, 6, 7'h03));
    emit(enc_i(2, 1, 3'd1, 4, 7'h13));
    emit(enc_i(128, 4, 3'd2, 7, 7'h03));
    emit(enc_r(7'h00, 1, 5, 3'd4, 8));
    emit(enc_r(7'h00, 8, 11, 3'd6, 11));
    emit(enc_r(7'h00, 1, 6, 3'd4, 8));
    emit(enc_r(7'h00, 8, 11, 3'd6, 11));
    emit(enc_r(7'h00, 1, 7, 3'd4, 8));
    emit(enc_r(7'h00, 8, 11, 3'd6, 11));
    emit(addi(1, 1, 1));
    emit(enc_b(-48, 2, 1, 3'd4));            // 92
    emit(enc_b(12, 0, 11, 3'd1));            // 96: bne x11,x0,+12
    emit(enc_u(20'h00006, 10, 7'h37));
    emit(addi(10, 10, 13));
    emit(32'h0010_0073);
  endtask

  task automatic build_misc();
    prog.delete();
    emit(addi(1, 0, 128));
    emit(enc_s(256, 1, 0, 3'd0));
    emit(enc_i(256, 0, 3'd0, 5, 7'h03));     // 8: lb
    emit(enc_i(256, 0, 3'd4, 12, 7'h03));    // 12: lbu
    emit(addi(0, 0, 5));
    emit(enc_u(20'h80000, 15, 7'h37));
    emit(enc_i(32'h404, 15, 3'd5, 16, 7'h13)); // 24: srai x16,x15,4
    emit(enc_i(32'h004, 15, 3'd5, 17, 7'h13));
    emit(enc_r(7'h20, 1, 0, 3'd0, 18));
    emit(enc_r(7'h00, 18, 1, 3'd3, 19));
    emit(enc_r(7'h00, 18, 1, 3'd2, 20));
    emit(enc_j(8, 21));                      // 44
    emit(addi(22, 0, 99));
    emit(enc_u(20'h00001, 23, 7'h17));       // 52: auipc
    emit(addi(26, 0, -2));
    emit(enc_b(8, 1, 26, 3'd7));             // 60: bgeu
    emit(addi(22, 0, 1));
    emit(enc_s(258, 26, 0, 3'd1));
    emit(enc_i(259, 0, 3'd1, 27, 7'h03));
    emit(enc_s(260, 15, 0, 3'd2));
    emit(enc_i(263, 0, 3'd2, 28, 7'h03));
    emit(addi(29, 0, 96));
    emit(enc_i(0, 29, 3'd0, 30, 7'h67));     // 88: jalr
    emit(addi(22, 0, 2));
    emit(32'h0010_0073);
  endtask

  task automatic start_prog(input bit check_reset);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) dut.u_code_memory.memory[i] = 32'h0000_0013;
    for (int i = 0; i < prog.size(); i++) dut.u_code_memory.memory[i] = prog[i];
    #1;
    if (check_reset) begin
      check("rst_halted", {31'h0, halted}, 32'h0);
      check("rst_pc", dut.u_cpu.r_pc, 32'h0);
      for (int i = 0; i < 32; i++)
        check($sformatf("rst_x%0d", i), dut.u_cpu.register_bank[i], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int unsigned budget, output int unsigned cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check("halt_reached", {31'h0, halted}, 32'h1);
  endtask

  function automatic logic [31:0] xr(input int n);
    return dut.u_cpu.register_bank[n];
  endfunction

  initial begin
    build_fib();
    start_prog(1'b1);
    run_to_halt(2000, cyc);
    check("fib_cycles", cyc, 32'd80);
    check("fib_pc", dut.u_cpu.r_pc, 32'd52);
    check("fib_x6", xr(6), 32'h0000_0179);
    check("fib_x10", xr(10), 32'h600D_600D);
    check("fib_mem52", {24'h0, dut.u_data_memory.r_mem[52]}, 32'h79);
    check("fib_mem53", {24'h0, dut.u_data_memory.r_mem[53]}, 32'h01);
    repeat (10) @(negedge clk);
    check("hold_halted", {31'h0, halted}, 32'h1);
    check("hold_pc", dut.u_cpu.r_pc, 32'd52);
    check("hold_x6", xr(6), 32'h0000_0179);
    check("hold_x2", xr(2), 32'd48);
    check("hold_x10", xr(10), 32'h600D_600D);

    #2 rst = 1'b1;
    #1;
    check("rsthalt_halted", {31'h0, halted}, 32'h0);
    check("rsthalt_pc", dut.u_cpu.r_pc, 32'h0);
    check("rsthalt_x6", xr(6), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_to_halt(2000, cyc);
    check("rerun_x10", xr(10), 32'h600D_600D);

    build_ldst();
    start_prog(1'b0);
    run_to_halt(2000, cyc);
    check("ldst_x11", xr(11), 32'h0);
    check("ldst_x10", xr(10), 32'h0000_600D);
    check("ldst_x1", xr(1), 32'd16);
    check("ldst_b5", {24'h0, dut.u_data_memory.r_mem[5]}, 32'd5);
    check("ldst_h7lo", {24'h0, dut.u_data_memory.r_mem[46]}, 32'd7);
    check("ldst_h7hi", {24'h0, dut.u_data_memory.r_mem[47]}, 32'd0);
    check("ldst_w15", {24'h0, dut.u_data_memory.r_mem[188]}, 32'd15);
    check("ldst_w15b1", {24'h0, dut.u_data_memory.r_mem[189]}, 32'd0);

    build_misc();
    start_prog(1'b0);
    run_to_halt(2000, cyc);
    check("lb_sext", xr(5), 32'hFFFF_FF80);
    check("lbu_zext", xr(12), 32'h0000_0080);
    check("x0_zero", xr(0), 32'h0);
    check("srai", xr(16), 32'hF800_0000);
    check("srli", xr(17), 32'h0800_0000);
    check("sub", xr(18), 32'hFFFF_FF80);
    check("sltu", xr(19), 32'h1);
    check("slt", xr(20), 32'h0);
    check("jal_link", xr(21), 32'd48);
    check("skipped", xr(22), 32'h0);
    check("auipc", xr(23), 32'h0000_1034);
    check("lh_align", xr(27), 32'hFFFF_FFFE);
    check("lw_align", xr(28), 32'h8000_0000);
    check("jalr_link", xr(30), 32'd92);
    check("misc_pc", dut.u_cpu.r_pc, 32'd96);

    build_fib();
    start_prog(1'b0);
    repeat (30) @(negedge clk);
    check("mid_running", {31'h0, halted}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("mid_x1", xr(1), 32'h0);
    check("mid_x3", xr(3), 32'h0);
    check("mid_pc", dut.u_cpu.r_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_to_halt(2000, cyc);
    check("mid_cycles", cyc, 32'd80);
    check("mid_x10", xr(10), 32'h600D_600D);
    check("mid_x6", xr(6), 32'h0000_0179);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_design.md
CPU_DESIGN -- requirements
Module: cpu_design

Interface
REQ-001 SHALL have parameter CODE_WORDS, default 1024, giving the number of 32-bit instruction words in code memory.
REQ-002 SHALL have parameter DATA_BYTES, default 4096, giving the data memory size in bytes.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port halted, output, 1 bit: high once EBREAK has retired; sticky until reset.
REQ-006 SHALL contain instance u_code_memory, holding array memory[0:CODE_WORDS-1] of 32-bit words, indexed by PC[31:2] and writable hierarchically by the bench before reset deasserts.
REQ-007 SHALL contain instance u_cpu, holding array register_bank[0:31] of 32-bit registers (x0..x31), readable hierarchically.

Function
REQ-008 SHALL implement an RV32I integer subset as a single-cycle, non-pipelined core: one instruction retires per clk edge while not halted.
REQ-009 SHALL support LUI, AUIPC, JAL and JALR; JAL/JALR write PC+4 to rd.
REQ-010 SHALL support BEQ, BNE, BLT, BGE, BLTU and BGEU with target = PC of the branch + sign-extended byte offset; not taken -> PC+4.
REQ-011 SHALL support LB, LH, LW, LBU and LHU; LB/LH sign-extend and LBU/LHU zero-extend.
REQ-012 SHALL support SB, SH and SW; only the addressed byte lanes are written.
REQ-013 SHALL support ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI and SRAI.
REQ-014 SHALL support ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL and SRA.
REQ-015 SHALL wrap all arithmetic modulo 2^32; shift amounts use bits [4:0] only.
REQ-016 SHALL use standard RISC-V immediate formats, sign-extended to 32 bits.
REQ-017 SHALL hard-wire x0 to zero; writes to x0 are discarded.
REQ-018 SHALL make data memory byte-addressable and little-endian.
REQ-019 SHALL read data memory combinationally in the same cycle and write it on the rising clk edge.
REQ-020 SHALL use address modulo DATA_BYTES for data memory.
REQ-021 SHALL force halfword addresses to bit0=0 and word addresses to bits[1:0]=0 (aligned down, no trap).
REQ-022 SHALL fetch combinationally from u_code_memory.memory[PC[31:2] mod CODE_WORDS].
REQ-023 SHALL, on EBREAK (0x00100073), stop PC advance, suppress all register and memory writes, and set halted=1 on that edge.
REQ-024 SHALL, while halted=1, leave all architectural state frozen.
REQ-025 SHALL execute ECALL, FENCE and any unrecognised encoding as NOP (PC+4, no writes).
REQ-026 SHALL apply a register write and a next-PC update on the same edge; a source register equal to rd reads the old value.

Reset
REQ-027 SHALL, while rst=1, asynchronously force PC=0, register_bank all zero and halted=0.
REQ-028 SHALL NOT clear code memory or data memory on reset.
REQ-029 SHALL, on assertion of rst mid-execution or while halted, abort immediately; execution restarts at PC=0 on the first clk edge after rst falls.

Verification
REQ-030 SHALL pass a Fibonacci program (seed 1,1 at data addresses 0/4, 12-iteration lw/lw/add/sw loop via BLT offset -20) with x6=377 (0x179) and x10=0x600D600D at halt.
REQ-031 SHALL pass a store/load loop: SB values 0..15 at bytes 0..15, SH 0..15 at 32.., SW 0..15 at 128..; every readback equal; x10 low half=0x600D.
REQ-032 SHALL produce x5=0xFFFFFF80 for SB 0x80 then LB, and x5=0x00000080 for LBU of the same byte.
REQ-033 SHALL leave x0=0 after ADDI x0,x0,5.
REQ-034 SHALL, on EBREAK, assert halted on the next edge; PC and registers stay unchanged for 10 further cycles.
REQ-035 SHALL, on rst asserted mid-loop, zero registers and halted at once; after release, the program reruns from PC 0 to the same final x10.
